// File: rtl/ex_muldiv.sv
// Iterative unsigned MULTU/DIVU unit: one bit per cycle, 64-bit result to HI/LO.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise only MULTU runs.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             op_in,
  input  logic [WIDTH-1:0] Read_D1_in,
  input  logic [WIDTH-1:0] Read_D2_in,
  output logic             busy_out,
  output logic             stall_out,
  output logic             done_out,
  output logic             div_zero_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               cnt_last;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nxt;

  assign cnt_last = (cnt_q == 6'(WIDTH-1));

  // Carry of the upper-half add lands in the MSB after the right shift.
  assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                            : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] b_q, rem_q, quo_q;
  logic             op_q, dz_q;
  logic [WIDTH:0]   r_sh, r_diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // Stored remainder is always below B, so its WIDTH+1'th bit is implicitly 0.
  assign r_sh    = {rem_q, quo_q[WIDTH-1]};
  assign r_diff  = r_sh - {1'b0, b_q};
  assign rem_nxt = r_diff[WIDTH] ? r_sh[WIDTH-1:0] : r_diff[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ~r_diff[WIDTH]};
  assign div_zero_out = dz_q;
`else
  assign div_zero_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_in && !op_in) state_d = S_MUL;
`ifdef MULDIV_DIV_EN
        else if (start_in && op_in) state_d = S_DIV;
`endif
      end
      S_MUL, S_DIV: if (cnt_last) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out  = (state_q != S_IDLE);
    stall_out = (state_q != S_IDLE);
  end

  assign done_out = done_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      op_q   <= 1'b0;
      dz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in && !op_in) begin
            a_q   <= Read_D1_in;
            acc_q <= {{WIDTH{1'b0}}, Read_D2_in};
            cnt_q <= '0;
`ifdef MULDIV_DIV_EN
            op_q  <= 1'b0;
          end else if (start_in && op_in) begin
            b_q   <= Read_D2_in;
            quo_q <= Read_D1_in;
            rem_q <= '0;
            cnt_q <= '0;
            op_q  <= 1'b1;
`endif
          end
        end
        S_MUL: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 6'd1;
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 6'd1;
        end
`endif
        S_DONE: begin
          done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (op_q) begin
            hi_q <= rem_q;
            lo_q <= quo_q;
            dz_q <= (b_q == '0);
          end else begin
            hi_q <= acc_q[2*WIDTH-1:WIDTH];
            lo_q <= acc_q[WIDTH-1:0];
            dz_q <= 1'b0;
          end
`else
          hi_q <= acc_q[2*WIDTH-1:WIDTH];
          lo_q <= acc_q[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized + directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] d1, d2;
  logic         busy, stall, done, dz;
  logic [W-1:0] hi, lo;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_in(start), .op_in(op),
    .Read_D1_in(d1), .Read_D2_in(d2),
    .busy_out(busy), .stall_out(stall), .done_out(done),
    .div_zero_out(dz), .hi_out(hi), .lo_out(lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit div_en;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    if (!o) begin
      p = 64'(a) * 64'(b);
      m_hi = p[63:32]; m_lo = p[31:0]; m_dz = 1'b0;
    end else if (div_en) begin
      if (b == 0) begin m_hi = a; m_lo = '1; m_dz = 1'b1; end
      else begin m_hi = a % b; m_lo = a / b; m_dz = 1'b0; end
    end
  endtask

  // inj > 0: pulse a DIVU start inj+1 edges after capture; do_rst: reset at edge N+10
  task automatic run_op(input bit o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, input bit do_rst);
    bit acc;
    int cyc, busy_n, extra;
    logic [63:0] prev;
    acc  = !o || div_en;
    prev = {m_hi, m_lo};
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(posedge clk); #1;
    start = 1'b0; d1 = $urandom; d2 = $urandom;
    chk("busy_at_start", busy, acc);
    chk("stall_at_start", stall, acc);
    if (!acc) begin
      repeat (5) begin
        @(posedge clk); #1;
        chk("ignored_busy", busy, 0);
        chk("ignored_done", done, 0);
      end
      chk("ignored_hilo", {hi, lo}, prev);
      return;
    end
    busy_n = 1; cyc = 0;
    while (cyc < 100 && !done) begin
      if (do_rst && cyc == 9) rst = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (do_rst && cyc == 10) begin
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dz", dz, 0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (done) extra++; end
        chk("rst_no_done", extra, 0);
        return;
      end
      if (inj > 0 && cyc == inj) begin start = 1'b1; op = 1'b1; d1 = 9; d2 = 3; end
      if (inj > 0 && cyc == inj + 1) start = 1'b0;
      if (busy) busy_n++;
      if (!done) chk("hilo_hold", {hi, lo}, prev);
    end
    chk("latency", cyc, W + 1);
    chk("busy_cycles", busy_n, W + 1);
    model(o, a, b);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("div_zero", dz, m_dz);
    @(posedge clk); #1;
    chk("done_falls", done, 0);
    chk("idle_busy", busy, 0);
    if (inj > 0) begin
      extra = 0;
      repeat (40) begin @(posedge clk); #1; if (done) extra++; end
      chk("no_queued_op", extra, 0);
      chk("inj_lo", lo, m_lo);
    end
  endtask

  initial begin
`ifdef MULDIV_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    rst = 1'b1; start = 1'b1; op = 1'b0; d1 = 5; d2 = 5;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", dz, 0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 6, 7, 0, 0);
    chk("mul_6x7_lo", lo, 32'h2A);
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    chk("mul_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(1, 100, 7, 0, 0);
    run_op(1, 32'h12345678, 0, 0, 0);
    run_op(0, 2, 3, 0, 0);
    chk("mul_2x3_lo", lo, 6);
    run_op(0, 6, 7, 4, 0);
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? '0 : $urandom >> $urandom_range(0, 28);
      run_op(1'($urandom_range(0, 1)), ra, rb, 0, 0);
    end
    run_op(0, 32'hDEADBEEF, 32'h1234, 0, 0);
    run_op(0, 6, 7, 0, 1);
    run_op(0, 3, 5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
